// File: rtl/demux_seq_pkg.sv
// rtl/demux_seq_pkg.sv - shared state encoding and widths for the demux sequencer
package demux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int CH_W        = 2;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/demux4x1.sv
// rtl/demux4x1.sv - 4-way 1-bit demultiplexer fed by the sequencer
module demux4x1 (
  input  logic d,
  input  logic s0,
  input  logic s1,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  assign y0 = d & ~s1 & ~s0;
  assign y1 = d & ~s1 &  s0;
  assign y2 = d &  s1 & ~s0;
  assign y3 = d &  s1 &  s0;

endmodule

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-in/serial-out register, MSB shifted out first
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] par_data,
  output logic              msb
);

  logic [DATA_W-1:0] sreg;

  // load wins over shift so a new word is never corrupted on its accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= par_data;
    end else if (shift) begin
      sreg <= {sreg[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = sreg[DATA_W-1];

endmodule

// File: rtl/demux_seq_ctrl.sv
// rtl/demux_seq_ctrl.sv - frames tagged words as start bit, MSB-first data and gap
// onto the demux data line, holding the select steady for the whole frame
module demux_seq_ctrl
  import demux_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CH_W-1:0]        in_ch,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   d,
  output logic                   s0,
  output logic                   s1,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CH_W-1:0]  sel;
  logic             accept;
  logic             shift_en;
  logic             msb;

  assign accept   = (state == IDLE) && in_valid;
  assign shift_en = (state == SHIFT);

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (shift_en),
    .par_data (in_data),
    .msb      (msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sel       <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // select only moves here, where d is guaranteed low
          if (in_valid) begin
            sel   <= in_ch;
            state <= START;
          end
        end
        START: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= GAP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // all outputs decode registered state only, so reset clears them at once
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == GAP);
  assign d        = (state == START) || ((state == SHIFT) && msb);
  assign s0       = sel[0];
  assign s1       = sel[1];

endmodule

// File: tb/tb_demux_seq_ctrl.sv
// tb/tb_demux_seq_ctrl.sv - directed self-checking bench for demux_seq_ctrl driving demux4x1
module tb_demux_seq_ctrl;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_ch;
  logic              in_valid;
  logic              in_ready;
  logic              d, s0, s1, busy, done;
  logic [7:0]        frame_cnt;
  logic              y0, y1, y2, y3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_seq_ctrl #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_ch     (in_ch),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .s0        (s0),
    .s1        (s1),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  demux4x1 u_demux (
    .d  (d),
    .s0 (s0),
    .s1 (s1),
    .y0 (y0),
    .y1 (y1),
    .y2 (y2),
    .y3 (y3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || d !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: in_ready=%b d=%b required 1 0", in_ready, d);
    end
    @(negedge clk); rst = 1'b0;
    in_data = 8'hFF; in_ch = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (d !== 1'b0 || {s1, s0} !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_midrun: d=%b sel=%b busy=%b in_ready=%b frame_cnt=%0d required 0 00 0 1 0",
               d, {s1, s0}, busy, in_ready, frame_cnt);
    end
    in_valid = 1'b1;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_accept: busy=%b required 0", busy);
    end
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick();
    n_checks++;
    if (d !== 1'b0 || {s1, s0} !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_release: d=%b sel=%b busy=%b in_ready=%b frame_cnt=%0d required 0 00 0 1 0",
               d, {s1, s0}, busy, in_ready, frame_cnt);
    end
  endtask

  task automatic test_single();
    logic [9:0] exp_seq;
    logic [7:0] cnt0;
    int         bad;
    exp_seq = 10'b1101001010;
    cnt0 = frame_cnt;
    bad = 0;
    in_data = 8'hA5; in_ch = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (d !== exp_seq[9-c] || {s1, s0} !== 2'b10 || y2 !== exp_seq[9-c] ||
          (y0 | y1 | y3) !== 1'b0 || done !== (c == 9)) begin
        n_fail++; bad++;
        $display("FAIL single_cycle%0d: d=%b sel=%b y=%b%b%b%b done=%b required d=%b sel=10 done=%b",
                 c + 1, d, {s1, s0}, y3, y2, y1, y0, done, exp_seq[9-c], c == 9);
      end
      tick();
    end
    n_checks++;
    if (frame_cnt !== cnt0 + 8'd1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_end: frame_cnt=%0d in_ready=%b required %0d 1", frame_cnt, in_ready, cnt0 + 8'd1);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    int   starts[$];
    int   y0_hi, y3_hi, glitch;
    logic prev_d, prev_ready;
    logic [1:0] prev_sel;
    y0_hi = 0; y3_hi = 0; glitch = 0;
    prev_d = d; prev_ready = in_ready; prev_sel = {s1, s0};
    in_data = 8'hFF; in_ch = 2'd0; in_valid = 1'b1;
    for (cyc = 1; cyc <= 22; cyc++) begin
      tick();
      if (d && prev_ready) starts.push_back(cyc);
      if ({s1, s0} !== prev_sel && prev_d !== 1'b0) glitch++;
      if (y0) y0_hi++;
      if (y3) y3_hi++;
      if (cyc == 1) begin
        in_data = 8'h00; in_ch = 2'd3;
      end
      if (starts.size() == 2) in_valid = 1'b0;
      prev_d = d; prev_ready = in_ready; prev_sel = {s1, s0};
    end
    in_valid = 1'b0;
    n_checks++;
    if (starts.size() != 2) begin
      n_fail++; $display("FAIL b2b_starts: count=%0d required 2", starts.size());
    end else begin
      n_checks++;
      if (starts[1] - starts[0] != 11) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d required 11", starts[1] - starts[0]);
      end
    end
    n_checks++;
    if (glitch != 0) begin
      n_fail++; $display("FAIL b2b_sel_change_with_d_high: got %0d required 0", glitch);
    end
    n_checks++;
    if (y0_hi != 9 || y3_hi != 1) begin
      n_fail++; $display("FAIL b2b_bursts: y0=%0d y3=%0d required 9 1", y0_hi, y3_hi);
    end
    n_checks++;
    if ({s1, s0} !== 2'b11 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: sel=%b busy=%b required 11 0", {s1, s0}, busy);
    end
  endtask

  task automatic test_abort();
    logic [9:0] exp_seq;
    int         dones;
    exp_seq = {1'b1, 8'h3C, 1'b0};
    dones = 0;
    rst = 1'b1; tick(); @(negedge clk); rst = 1'b0;
    in_data = 8'h3C; in_ch = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (d !== 1'b1 || {s1, s0} !== 2'b01 || y1 !== 1'b1) begin
      n_fail++; $display("FAIL abort_start: d=%b sel=%b y1=%b required 1 01 1", d, {s1, s0}, y1);
    end
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (d !== 1'b0 || {s1, s0} !== 2'b00 || done !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_immediate: d=%b sel=%b done=%b busy=%b frame_cnt=%0d required 0 00 0 0 0",
               d, {s1, s0}, done, busy, frame_cnt);
    end
    tick(); tick();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    n_checks++;
    if (dones != 0 || frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL abort_no_done: dones=%0d frame_cnt=%0d required 0 0", dones, frame_cnt);
    end
    in_data = 8'h3C; in_ch = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (d !== exp_seq[9-c] || {s1, s0} !== 2'b01 || y1 !== exp_seq[9-c]) begin
        n_fail++;
        $display("FAIL abort_resend_cycle%0d: d=%b sel=%b y1=%b required %b 01", c + 1, d, {s1, s0}, y1, exp_seq[9-c]);
      end
      tick();
    end
    n_checks++;
    if (frame_cnt !== 8'd1) begin
      n_fail++; $display("FAIL abort_resend_count: frame_cnt=%0d required 1", frame_cnt);
    end
  endtask

  task automatic test_ignored_input();
    logic [9:0] exp_seq;
    exp_seq = {1'b1, 8'h96, 1'b0};
    in_data = 8'h96; in_ch = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (d !== exp_seq[9-c] || {s1, s0} !== 2'b01 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ignored_cycle%0d: d=%b sel=%b busy=%b required %b 01 1", c + 1, d, {s1, s0}, busy, exp_seq[9-c]);
      end
      in_data  = 8'($urandom);
      in_ch    = 2'($urandom);
      in_valid = (c >= 1 && c <= 7) ? 1'b1 : 1'b0;
      tick();
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || {s1, s0} !== 2'b01) begin
      n_fail++; $display("FAIL ignored_end: busy=%b sel=%b required 0 01", busy, {s1, s0});
    end
  endtask

  task automatic test_counter_wrap();
    int dones;
    int cyc;
    dones = 0;
    rst = 1'b1; tick(); @(negedge clk); rst = 1'b0;
    in_data = 8'h5A; in_ch = 2'd2; in_valid = 1'b1;
    for (cyc = 0; cyc < 4000 && dones < 256; cyc++) begin
      tick();
      if (done) begin
        dones++;
        if (dones == 256) begin
          in_valid = 1'b0;
          n_checks++;
          if (frame_cnt !== 8'd255) begin
            n_fail++; $display("FAIL wrap_pre: frame_cnt=%0d required 255", frame_cnt);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (dones != 256) begin
      n_fail++; $display("FAIL wrap_dones: got %0d required 256", dones);
    end
    tick();
    tick();
    n_checks++;
    if (frame_cnt !== 8'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_post: frame_cnt=%0d busy=%b required 0 0", frame_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_single();
    test_back_to_back();
    test_ignored_input();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
